multi_line_buffer: RTL and testbench

MULTI_LINE_BUFFER -- requirements
Module: multi_line_buffer

---
 rtl/multi_line_buffer.sv | 123 ++++++++++++
 tb/tb_multi_line_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multi_line_buffer.sv
// Line buffer holding KERNEL_SIZE-1 image lines; emits one vertical pixel column per accepted pixel.
// Define LB_BORDER_FLAG_EN to add the out_border port (column lies inside the left kernel border).
module multi_line_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 854,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  input  logic                              in_sof,
  output logic                              in_ready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]      out_col
`ifdef LB_BORDER_FLAG_EN
  ,
  output logic                              out_border
`endif
);

  // state    | meaning
  // S_PRIME  | filling line memories after reset or sof, no output
  // S_STREAM | KERNEL_SIZE-1 lines stored, every accept emits a column

  localparam int LINES = KERNEL_SIZE - 1;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(KERNEL_SIZE);

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_PRIME = RW'(KERNEL_SIZE - 2);

  typedef enum logic {S_PRIME = 1'b0, S_STREAM = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;
  logic          accept, col_last, emit;

  logic [DATA_WIDTH-1:0]             line_rd [LINES];
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] col_vec;

  assign in_ready = out_ready || !out_valid;
  assign accept   = in_valid && in_ready;

  // An sof pixel restarts the frame: it is handled as column 0 of row 0.
  assign col_eff  = in_sof ? '0 : col;
  assign row_eff  = in_sof ? '0 : row;
  assign col_last = (col_eff == COL_MAX);
  assign emit     = accept && (state == S_STREAM) && !in_sof;

  assign col_vec[DATA_WIDTH-1:0] = in_data;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    logic [DATA_WIDTH-1:0] ram [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] wr_data;

    if (i == 0) begin : g_first
      assign wr_data = in_data;
    end else begin : g_shift
      assign wr_data = line_rd[i-1];
    end

    // Nonblocking write gives read-before-write, so every line shifts down by one at once.
    always_ff @(posedge clk) begin
      if (accept) ram[col_eff] <= wr_data;
    end

    assign line_rd[i] = ram[col_eff];
    assign col_vec[(i+1)*DATA_WIDTH +: DATA_WIDTH] = line_rd[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_PRIME;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_sof) state_nxt = S_PRIME;
      if (row_eff == ROW_PRIME && col_last) state_nxt = S_STREAM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_last ? '0 : col_eff + 1'b1;
      row <= (col_last && row_eff != ROW_MAX) ? row_eff + 1'b1 : row_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= col_vec;
      out_col   <= col_eff;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LB_BORDER_FLAG_EN
  localparam logic [CW-1:0] BORDER_LIM = CW'(KERNEL_SIZE - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       out_border <= 1'b0;
    else if (emit) out_border <= (col_eff < BORDER_LIM);
  end
`endif

endmodule

// File: tb/tb_multi_line_buffer.sv
// Scoreboard bench for multi_line_buffer (IMG_WIDTH=8, KERNEL_SIZE=3, DATA_WIDTH=8).
// Expected columns come from a reference line-store model and are queued on every emitting accept.
module tb_multi_line_buffer;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int K  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_ready;
  logic [K*DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2:0]    out_col;
`ifdef LB_BORDER_FLAG_EN
  logic          out_border;
`endif

  multi_line_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .KERNEL_SIZE(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col)
`ifdef LB_BORDER_FLAG_EN
    ,
    .out_border(out_border)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [K*DW-1:0] data;
    logic [2:0]      col;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // reference model
  logic [DW-1:0] m0 [IW];
  logic [DW-1:0] m1 [IW];
  int  mcol = 0, mrow = 0, pix = 0;
  bit  mstream = 1'b0, m_ov = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input bit sof, output bit emit);
    int c, r;
    exp_t e;
    c = sof ? 0 : mcol;
    r = sof ? 0 : mrow;
    emit = mstream && !sof;
    if (emit) begin
      e.data = {m1[c], m0[c], d};
      e.col  = 3'(c);
      sb.push_back(e);
    end
    m1[c] = m0[c];
    m0[c] = d;
    if (sof) mstream = 1'b0;
    if (r == K - 2 && c == IW - 1) mstream = 1'b1;
    mrow = (c == IW - 1 && r < K - 1) ? r + 1 : r;
    mcol = (c == IW - 1) ? 0 : c + 1;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("out_data", out_data, e.data);
      check("out_col", out_col, e.col);
`ifdef LB_BORDER_FLAG_EN
      check("out_border", out_border, (e.col < 3'(K - 1)));
`endif
      if (e.data == 24'h000810) check("first_col", out_data, 24'h000810);
      if (e.data[7:0] == 8'd39 && e.col == 3'd7) check("px39_col", out_data, 24'h171F27);
    end
  endtask

  task automatic step(input bit v, input bit sof, input bit rdy);
    bit pop, emit, rdy_exp;
    @(negedge clk);
    if (sof) pix = 0;
    in_valid  = v;
    in_sof    = sof;
    in_data   = pix[DW-1:0];
    out_ready = rdy;
    #1;
    rdy_exp = rdy || !m_ov;
    check("out_valid", out_valid, m_ov);
    check("in_ready", in_ready, rdy_exp);
    pop  = m_ov && rdy;
    emit = 1'b0;
    if (pop) pop_check();
    if (v && rdy_exp) begin
      model_accept(pix[DW-1:0], sof, emit);
      pix++;
    end
    m_ov = emit ? 1'b1 : (pop ? 1'b0 : m_ov);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_out_col", out_col, '0);
`ifdef LB_BORDER_FLAG_EN
    check("rst_out_border", out_border, 1'b0);
`endif
    m_ov = 1'b0; mstream = 1'b0; mcol = 0; mrow = 0; pix = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K*DW-1:0] hold_data;
    logic [2:0]      hold_col;

    do_reset();

    // continuous stream: 16 priming accepts, then columns from pixel 16 onward
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1);

    // downstream stall with a pending column
    step(1'b1, 1'b0, 1'b0);
    hold_data = out_data;
    hold_col  = out_col;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("hold_data", out_data, hold_data);
      check("hold_col", out_col, hold_col);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);

    // sof on the 20th pixel of a fresh frame re-primes the buffer
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b1);

    // random valid/ready with occasional sof
    for (int i = 0; i < 300; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(63, 0) == 0, $urandom_range(2, 0) != 0);

    // reset mid-stream at row 2 col 4, then re-prime
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40 && !(mrow == 2 && mcol == 4); i++) step(1'b1, 1'b0, 1'b1);
    check("mid_out_valid_pre", out_valid, 1'b1);
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
